// File: rtl/dft_pkg.sv
// ============================================================================
// Package     : dft_pkg
// Description : Constants, FSM state type and the +/-1, +/-j twiddle sign table
//               shared by the 4-point forward and inverse DFT blocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dft_pkg;

   localparam int W = 16;   // sample width, signed Q1.15
   localparam int N = 4;    // transform length

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Rotation of a complex value (A + jB) by j^m, for m = (k*n) % 4.
   // re_from_im / im_from_re pick the swapped component; *_neg negates it.
   // The forward DFT rotates by (-j)^m, which is the same table at index
   // (-k*n) % 4.
   typedef struct packed {
      logic re_from_im;
      logic re_neg;
      logic im_from_re;
      logic im_neg;
   } twiddle_t;

   function automatic twiddle_t twiddle_sel(input logic [1:0] m);
      twiddle_t t;
      case (m)
         2'd0:    t = '{re_from_im: 1'b0, re_neg: 1'b0, im_from_re: 1'b0, im_neg: 1'b0}; //  A + jB
         2'd1:    t = '{re_from_im: 1'b1, re_neg: 1'b1, im_from_re: 1'b1, im_neg: 1'b0}; // -B + jA
         2'd2:    t = '{re_from_im: 1'b0, re_neg: 1'b1, im_from_re: 1'b0, im_neg: 1'b1}; // -A - jB
         default: t = '{re_from_im: 1'b1, re_neg: 1'b0, im_from_re: 1'b1, im_neg: 1'b1}; //  B - jA
      endcase
      return t;
   endfunction

endpackage

`default_nettype wire

// File: rtl/idft4_point_calc.sv
// ============================================================================
// Module      : idft4_point_calc
// Description : Combinational evaluation of one inverse-DFT output sample
//               x[n] = (1/4) * sum_k X[k] * j^(k*n). Operands are sign-extended
//               by two bits so the 4-term sum cannot overflow; the result is
//               the sum shifted right arithmetically by two (floor rounding).
// Ports       : i_a  - registered real parts of X[0..3]
//               i_b  - registered imaginary parts of X[0..3]
//               i_n  - output sample index 0..3
//               o_re - real part of x[n]
//               o_im - imaginary part of x[n]
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module idft4_point_calc
   import dft_pkg::*;
#(
   parameter int W = dft_pkg::W
) (
   input  logic [3:0][W-1:0] i_a,
   input  logic [3:0][W-1:0] i_b,
   input  logic [1:0]        i_n,
   output logic [W-1:0]      o_re,
   output logic [W-1:0]      o_im
);

   logic [1:0]   w_m;
   twiddle_t     w_tw;
   logic [W+1:0] w_a;
   logic [W+1:0] w_b;
   logic [W+1:0] w_re_src;
   logic [W+1:0] w_im_src;
   logic [W+1:0] w_sum_re;
   logic [W+1:0] w_sum_im;

   always_comb begin
      w_m      = '0;
      w_tw     = '0;
      w_a      = '0;
      w_b      = '0;
      w_re_src = '0;
      w_im_src = '0;
      w_sum_re = '0;
      w_sum_im = '0;
      for (int k = 0; k < 4; k++) begin
         // 2-bit product wraps naturally, giving (k*n) % 4
         w_m      = 2'(k) * i_n;
         w_tw     = twiddle_sel(w_m);
         w_a      = {{2{i_a[k][W-1]}}, i_a[k]};
         w_b      = {{2{i_b[k][W-1]}}, i_b[k]};
         w_re_src = w_tw.re_from_im ? w_b : w_a;
         w_im_src = w_tw.im_from_re ? w_a : w_b;
         w_sum_re = w_tw.re_neg ? (w_sum_re - w_re_src) : (w_sum_re + w_re_src);
         w_sum_im = w_tw.im_neg ? (w_sum_im - w_im_src) : (w_sum_im + w_im_src);
      end
   end

   // >>>2 then truncate to W bits; the scaled range always fits in W bits
   assign o_re = w_sum_re[W+1:2];
   assign o_im = w_sum_im[W+1:2];

endmodule

`default_nettype wire

// File: rtl/idft4point.sv
// ============================================================================
// Module      : idft4point
// Description : Sequential 4-point inverse DFT. Captures four complex Q1.15
//               bins on start, emits one time sample per cycle into the output
//               registers (index 0..3), then pulses done for one cycle.
// Ports       : clk, reset_n         - clock, asynchronous active-low reset
//               start                - request, sampled only while idle
//               Xr0..Xr3, Xi0..Xi3   - real / imaginary input bins
//               xr0..xr3, xi0..xi3   - real / imaginary time samples (registered)
//               busy                 - transform in progress
//               done                 - one-cycle pulse, all outputs valid
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module idft4point
   import dft_pkg::*;
#(
   parameter int W = dft_pkg::W,
   parameter int N = dft_pkg::N
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start,
   input  logic signed [W-1:0] Xr0,
   input  logic signed [W-1:0] Xr1,
   input  logic signed [W-1:0] Xr2,
   input  logic signed [W-1:0] Xr3,
   input  logic signed [W-1:0] Xi0,
   input  logic signed [W-1:0] Xi1,
   input  logic signed [W-1:0] Xi2,
   input  logic signed [W-1:0] Xi3,
   output logic signed [W-1:0] xr0,
   output logic signed [W-1:0] xr1,
   output logic signed [W-1:0] xr2,
   output logic signed [W-1:0] xr3,
   output logic signed [W-1:0] xi0,
   output logic signed [W-1:0] xi1,
   output logic signed [W-1:0] xi2,
   output logic signed [W-1:0] xi3,
   output logic                busy,
   output logic                done
);

   generate
      if (N != 4) begin : g_bad_n
         $error("idft4point: only N = 4 is supported");
      end
   endgenerate

   state_t           r_state;
   logic [1:0]       r_n;
   logic [3:0][W-1:0] r_a;
   logic [3:0][W-1:0] r_b;
   logic [3:0][W-1:0] r_xr;
   logic [3:0][W-1:0] r_xi;
   logic             r_busy;
   logic             r_done;

   logic [W-1:0]     w_re;
   logic [W-1:0]     w_im;

   idft4_point_calc #(
      .W (W)
   ) u_calc (
      .i_a  (r_a),
      .i_b  (r_b),
      .i_n  (r_n),
      .o_re (w_re),
      .o_im (w_im)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_n     <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_xr    <= '0;
         r_xi    <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_a     <= {Xr3, Xr2, Xr1, Xr0};
                  r_b     <= {Xi3, Xi2, Xi1, Xi0};
                  r_n     <= '0;
                  r_busy  <= 1'b1;
                  r_state <= CALC;
               end
            end
            CALC: begin
               r_xr[r_n] <= w_re;
               r_xi[r_n] <= w_im;
               r_n       <= r_n + 2'd1;
               if (r_n == 2'd3) begin
                  // done rises together with the last sample write
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end
            end
            DONE: begin
               r_done  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign xr0  = r_xr[0];
   assign xr1  = r_xr[1];
   assign xr2  = r_xr[2];
   assign xr3  = r_xr[3];
   assign xi0  = r_xi[0];
   assign xi1  = r_xi[1];
   assign xi2  = r_xi[2];
   assign xi3  = r_xi[3];
   assign busy = r_busy;
   assign done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_idft4point.sv
// ============================================================================
// Module      : tb_idft4point
// Description : Self-checking bench for idft4point: directed vector table,
//               handshake / reset sequences and a forward-DFT round trip.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_idft4point;

   localparam int W = 16;

   typedef logic [3:0][15:0] v4_t;
   typedef struct packed {
      v4_t ar;
      v4_t ai;
      v4_t er;
      v4_t ei;
   } vec_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic start = 1'b0;
   logic signed [W-1:0] Xr0 = '0, Xr1 = '0, Xr2 = '0, Xr3 = '0;
   logic signed [W-1:0] Xi0 = '0, Xi1 = '0, Xi2 = '0, Xi3 = '0;
   logic signed [W-1:0] xr0, xr1, xr2, xr3;
   logic signed [W-1:0] xi0, xi1, xi2, xi3;
   logic busy, done;

   logic signed [W-1:0] o_xr [4];
   logic signed [W-1:0] o_xi [4];
   assign o_xr[0] = xr0;
   assign o_xr[1] = xr1;
   assign o_xr[2] = xr2;
   assign o_xr[3] = xr3;
   assign o_xi[0] = xi0;
   assign o_xi[1] = xi1;
   assign o_xi[2] = xi2;
   assign o_xi[3] = xi3;

   always #5 clk = ~clk;

   idft4point #(.W(16), .N(4)) dut (
      .clk(clk), .reset_n(reset_n), .start(start),
      .Xr0(Xr0), .Xr1(Xr1), .Xr2(Xr2), .Xr3(Xr3),
      .Xi0(Xi0), .Xi1(Xi1), .Xi2(Xi2), .Xi3(Xi3),
      .xr0(xr0), .xr1(xr1), .xr2(xr2), .xr3(xr3),
      .xi0(xi0), .xi1(xi1), .xi2(xi2), .xi3(xi3),
      .busy(busy), .done(done)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk_tol(input string nm, input int act, input int exp, input int tol);
      n_cmp++;
      if ((act - exp > tol) || (exp - act > tol)) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (tol %0d)", nm, act, exp, tol);
      end
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      chk_tol(nm, act, exp, 0);
   endtask

   function automatic v4_t pk(input int a0, input int a1, input int a2, input int a3);
      v4_t r;
      r[0] = a0[15:0];
      r[1] = a1[15:0];
      r[2] = a2[15:0];
      r[3] = a3[15:0];
      return r;
   endfunction

   function automatic int sx(input logic [15:0] v);
      return int'($signed(v));
   endfunction

   task automatic drive(input v4_t ar, input v4_t ai);
      Xr0 = ar[0]; Xr1 = ar[1]; Xr2 = ar[2]; Xr3 = ar[3];
      Xi0 = ai[0]; Xi1 = ai[1]; Xi2 = ai[2]; Xi3 = ai[3];
   endtask

   task automatic chk_outputs(input v4_t er, input v4_t ei, input int tol, input string nm);
      for (int i = 0; i < 4; i++) begin
         chk_tol($sformatf("%s xr%0d", nm, i), int'(o_xr[i]), sx(er[i]), tol);
         chk_tol($sformatf("%s xi%0d", nm, i), int'(o_xi[i]), sx(ei[i]), tol);
      end
   endtask

   // One full transform from IDLE, checking busy/done timing and results.
   task automatic run_vec(input v4_t ar, input v4_t ai, input v4_t er, input v4_t ei,
                          input int tol, input string nm);
      drive(ar, ai);
      start = 1'b1;
      @(posedge clk); #1;            // edge T
      start = 1'b0;
      chk({nm, " busy T+1"}, int'(busy), 1);
      chk({nm, " done T+1"}, int'(done), 0);
      for (int c = 2; c <= 4; c++) begin
         @(posedge clk); #1;
         chk($sformatf("%s busy T+%0d", nm, c), int'(busy), 1);
      end
      @(posedge clk); #1;            // edge T+4: last write, done rises
      chk({nm, " done T+5"}, int'(done), 1);
      chk({nm, " busy T+5"}, int'(busy), 0);
      chk_outputs(er, ei, tol, nm);
      @(posedge clk); #1;            // edge T+5: back to idle
      chk({nm, " done T+6"}, int'(done), 0);
   endtask

   vec_t tbl [9];
   v4_t  z4;

   initial begin
      int rises[$];
      logic prev;
      int xr[4], xi[4], Fr[4], Fi[4];

      z4 = pk(0, 0, 0, 0);
      //             Xr                          Xi                   expected xr              expected xi
      tbl[0] = {pk(4, 0, 0, 0),             z4,                  pk(1, 1, 1, 1),          z4};
      tbl[1] = {pk(0, 4, 0, 0),             z4,                  pk(1, 0, -1, 0),         pk(0, 1, 0, -1)};
      tbl[2] = {pk(32767, 32767, 32767, 32767), z4,              pk(32767, 0, 0, 0),      z4};
      tbl[3] = {pk(-32768, -32768, -32768, -32768), z4,          pk(-32768, 0, 0, 0),     z4};
      tbl[4] = {pk(3, 0, 0, 0),             z4,                  z4,                      z4};
      tbl[5] = {pk(-3, 0, 0, 0),            z4,                  pk(-1, -1, -1, -1),      z4};
      tbl[6] = {z4,                         pk(0, 0, 0, 8),      pk(0, 2, 0, -2),         pk(2, 0, -2, 0)};
      tbl[7] = {pk(100, 200, -300, 40),     pk(8, -12, 20, 4),   pk(10, 104, -110, 96),   pk(5, 37, 9, -43)};
      tbl[8] = {pk(-5, 0, 0, 0),            pk(0, 0, -1, 0),     pk(-2, -2, -2, -2),      pk(-1, 0, -1, 0)};

      // Reset state
      #8;
      chk("reset busy", int'(busy), 0);
      chk("reset done", int'(done), 0);
      chk_outputs(z4, z4, 0, "reset");
      #4 reset_n = 1'b1;
      @(posedge clk); #1;

      // Directed vector table
      for (int v = 0; v < 9; v++)
         run_vec(tbl[v].ar, tbl[v].ai, tbl[v].er, tbl[v].ei, 0, $sformatf("vec%0d", v));

      // start pulsed mid-CALC and inputs changed right after capture
      drive(tbl[7].ar, tbl[7].ai);
      start = 1'b1;
      @(posedge clk); #1;            // edge T
      start = 1'b0;
      drive(pk(4, 0, 0, 0), pk(1000, 1000, 1000, 1000));
      @(posedge clk); #1;            // edge T+1
      start = 1'b1;
      @(posedge clk); #1;            // edge T+2
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;            // edge T+4
      chk("ignore done", int'(done), 1);
      chk_outputs(tbl[7].er, tbl[7].ei, 0, "ignore");
      @(posedge clk); #1;
      @(posedge clk); #1;            // edge T+6: a queued request would show busy
      chk("no queue busy", int'(busy), 0);

      // start held high: a new transform every 6 cycles
      drive(pk(8, 0, 0, 0), z4);
      start = 1'b1;
      prev = busy;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         if (busy && !prev) rises.push_back(c);
         prev = busy;
      end
      start = 1'b0;
      chk("held start count", rises.size(), 4);
      for (int i = 1; i < rises.size(); i++)
         chk($sformatf("held spacing %0d", i), rises[i] - rises[i-1], 6);
      repeat (8) @(posedge clk);
      #1;
      chk_outputs(pk(2, 2, 2, 2), z4, 0, "held");

      // Asynchronous reset at T+2
      drive(tbl[7].ar, tbl[7].ai);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset_n = 1'b0;
      #1;
      chk("midrst busy", int'(busy), 0);
      chk("midrst done", int'(done), 0);
      chk_outputs(z4, z4, 0, "midrst");
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      run_vec(tbl[1].ar, tbl[1].ai, tbl[1].er, tbl[1].ei, 0, "postrst");

      // Round trip through an unscaled forward DFT
      for (int t = 0; t < 200; t++) begin
         for (int n = 0; n < 4; n++) begin
            xr[n] = int'($urandom_range(16000)) - 8000;
            xi[n] = int'($urandom_range(16000)) - 8000;
         end
         for (int k = 0; k < 4; k++) begin
            Fr[k] = 0;
            Fi[k] = 0;
            for (int n = 0; n < 4; n++) begin
               case ((k * n) % 4)
                  0: begin Fr[k] += xr[n]; Fi[k] += xi[n]; end
                  1: begin Fr[k] += xi[n]; Fi[k] -= xr[n]; end
                  2: begin Fr[k] -= xr[n]; Fi[k] -= xi[n]; end
                  default: begin Fr[k] -= xi[n]; Fi[k] += xr[n]; end
               endcase
            end
         end
         run_vec(pk(Fr[0], Fr[1], Fr[2], Fr[3]), pk(Fi[0], Fi[1], Fi[2], Fi[3]),
                 pk(xr[0], xr[1], xr[2], xr[3]), pk(xi[0], xi[1], xi[2], xi[3]),
                 2, $sformatf("rt%0d", t));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
